// File: rtl/seq_alu_pkg.sv
// rtl/seq_alu_pkg.sv - opcodes, FSM states and flag indices shared by seq_alu and its datapath
package seq_alu_pkg;

    localparam logic [3:0] OP_MUL  = 4'h3;
    localparam logic [3:0] OP_ADD  = 4'h4;
    localparam logic [3:0] OP_SUB  = 4'h5;
    localparam logic [3:0] OP_OR   = 4'h6;
    localparam logic [3:0] OP_AND  = 4'h7;
    localparam logic [3:0] OP_XOR  = 4'h8;
    localparam logic [3:0] OP_SHR  = 4'h9;
    localparam logic [3:0] OP_MOV  = 4'hA;
    localparam logic [3:0] OP_EXCH = 4'hB;
    localparam logic [3:0] OP_CMP  = 4'hC;
    localparam logic [3:0] OP_SET  = 4'hD;
    localparam logic [3:0] OP_CLR  = 4'hE;

    localparam int FLAG_Z = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_MUL   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/seq_alu_iter.sv
// rtl/seq_alu_iter.sv - iterative SHR / shift-add MUL datapath (MUL under SEQ_ALU_MUL_EN)
module seq_alu_iter #(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
`ifdef SEQ_ALU_MUL_EN
    input  logic               mul,
    input  logic [WIDTH-1:0]   b,
    output logic [WIDTH-1:0]   res_hi,
`endif
    input  logic [WIDTH-1:0]   a,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               done,
    output logic [WIDTH-1:0]   res_lo,
    output logic               last_out
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] lo;

    // res_lo/res_hi are the values after the current step, so the top can
    // capture the final result on the same edge that finishes the count.
`ifdef SEQ_ALU_MUL_EN
    logic             mode_mul;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH:0]   psum;

    assign psum   = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : '0);
    assign res_hi = psum[WIDTH:1];
    assign res_lo = mode_mul ? {psum[0], lo[WIDTH-1:1]} : {1'b0, lo[WIDTH-1:1]};
`else
    assign res_lo = {1'b0, lo[WIDTH-1:1]};
`endif

    assign last_out = lo[0];
    assign done     = (cnt == CNT_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            lo  <= '0;
`ifdef SEQ_ALU_MUL_EN
            hi       <= '0;
            mcand    <= '0;
            mode_mul <= 1'b0;
`endif
        end else if (start) begin
`ifdef SEQ_ALU_MUL_EN
            mode_mul <= mul;
            hi       <= '0;
            mcand    <= a;
            cnt      <= mul ? CNT_W'(WIDTH) : CNT_W'(shamt);
            lo       <= mul ? b : a;
`else
            cnt <= CNT_W'(shamt);
            lo  <= a;
`endif
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
            lo  <= res_lo;
`ifdef SEQ_ALU_MUL_EN
            hi  <= res_hi;
`endif
        end
    end

endmodule

// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - multi-cycle ALU with handshake and flag register; SEQ_ALU_MUL_EN adds opcode 3 MUL
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       opcode,
    input  logic [2:0]       flag_mask,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res_a,
    output logic [WIDTH-1:0] res_b,
    output logic             z_flag,
    output logic             n_flag,
    output logic             c_flag
);

    state_t           state;
    logic [2:0]       flags;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] nxt_a;
    logic [WIDTH-1:0] nxt_b;
    logic [2:0]       nxt_flags;
    logic             is_shr;
    logic             is_mul;
    logic             iter_start;
    logic             iter_done;
    logic             iter_last;
    logic [WIDTH-1:0] iter_lo;

    function automatic logic [2:0] arith_flags(input logic [WIDTH-1:0] r, input logic c);
        return {r == '0, r[WIDTH-1], c};
    endfunction

    assign sum  = {1'b0, a_in} + {1'b0, b_in};
    assign diff = {1'b0, a_in} - {1'b0, b_in};

    always_comb begin
        nxt_a     = a_in;
        nxt_b     = b_in;
        nxt_flags = flags;
        case (opcode)
            OP_ADD: begin
                nxt_a     = sum[WIDTH-1:0];
                nxt_flags = arith_flags(sum[WIDTH-1:0], sum[WIDTH]);
            end
            OP_SUB: begin
                nxt_a     = diff[WIDTH-1:0];
                nxt_flags = arith_flags(diff[WIDTH-1:0], diff[WIDTH]);
            end
            OP_CMP:  nxt_flags = arith_flags(diff[WIDTH-1:0], diff[WIDTH]);
            OP_OR: begin
                nxt_a     = a_in | b_in;
                nxt_flags = arith_flags(a_in | b_in, 1'b0);
            end
            OP_AND: begin
                nxt_a     = a_in & b_in;
                nxt_flags = arith_flags(a_in & b_in, 1'b0);
            end
            OP_XOR: begin
                nxt_a     = a_in ^ b_in;
                nxt_flags = arith_flags(a_in ^ b_in, 1'b0);
            end
            OP_MOV:  nxt_b = a_in;
            OP_EXCH: begin
                nxt_a = b_in;
                nxt_b = a_in;
            end
            OP_SET:  nxt_flags = flags | flag_mask;
            OP_CLR:  nxt_flags = flags & ~flag_mask;
            default: ;
        endcase
    end

    // SHR by zero takes the single-cycle path and falls through as a pass-through.
    assign is_shr = (opcode == OP_SHR) && (b_in[SHAMT_W-1:0] != '0);
`ifdef SEQ_ALU_MUL_EN
    assign is_mul = (opcode == OP_MUL);
`else
    assign is_mul = 1'b0;
`endif
    assign iter_start = (state == S_IDLE) && in_valid && (is_shr || is_mul);

`ifdef SEQ_ALU_MUL_EN
    logic [WIDTH-1:0] iter_hi;
`endif

    seq_alu_iter #(
        .WIDTH   (WIDTH),
        .SHAMT_W (SHAMT_W)
    ) u_iter (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (iter_start),
`ifdef SEQ_ALU_MUL_EN
        .mul      (is_mul),
        .b        (b_in),
        .res_hi   (iter_hi),
`endif
        .a        (a_in),
        .shamt    (b_in[SHAMT_W-1:0]),
        .done     (iter_done),
        .res_lo   (iter_lo),
        .last_out (iter_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            res_a     <= '0;
            res_b     <= '0;
            flags     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        in_ready <= 1'b0;
                        if (is_shr) begin
                            res_b <= b_in;
                            state <= S_SHIFT;
                        end else if (is_mul) begin
                            state <= S_MUL;
                        end else begin
                            res_a     <= nxt_a;
                            res_b     <= nxt_b;
                            flags     <= nxt_flags;
                            out_valid <= 1'b1;
                            state     <= S_DONE;
                        end
                    end
                end
                S_SHIFT: begin
                    if (iter_done) begin
                        res_a         <= iter_lo;
                        flags[FLAG_C] <= iter_last;
                        out_valid     <= 1'b1;
                        state         <= S_DONE;
                    end
                end
`ifdef SEQ_ALU_MUL_EN
                S_MUL: begin
                    if (iter_done) begin
                        res_a     <= iter_lo;
                        res_b     <= iter_hi;
                        flags     <= {(iter_lo == '0) && (iter_hi == '0),
                                      iter_hi[WIDTH-1], iter_hi != '0};
                        out_valid <= 1'b1;
                        state     <= S_DONE;
                    end
                end
`endif
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign z_flag = flags[FLAG_Z];
    assign n_flag = flags[FLAG_N];
    assign c_flag = flags[FLAG_C];

endmodule

// File: tb/tb_seq_alu.sv
// tb/tb_seq_alu.sv - directed self-checking bench for seq_alu (WIDTH=16)
module tb_seq_alu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  opcode;
    logic [2:0]  flag_mask;
    logic [15:0] a_in;
    logic [15:0] b_in;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] res_a;
    logic [15:0] res_b;
    logic        z_flag;
    logic        n_flag;
    logic        c_flag;

    int checks   = 0;
    int failures = 0;
    int lat;

    seq_alu #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opcode    (opcode),
        .flag_mask (flag_mask),
        .a_in      (a_in),
        .b_in      (b_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res_a     (res_a),
        .res_b     (res_b),
        .z_flag    (z_flag),
        .n_flag    (n_flag),
        .c_flag    (c_flag)
    );

    always #5 clk = ~clk;

    task automatic run_op(input logic [3:0] op, input logic [2:0] mask,
                          input logic [15:0] a, input logic [15:0] b, output int l);
        @(negedge clk);
        opcode = op; flag_mask = mask; a_in = a; b_in = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        l = 1;
        while (!out_valid && l < 64) begin
            @(posedge clk); #1;
            l++;
        end
    endtask

    task automatic take_result(input string name);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s handshake: out_valid=%b in_ready=%b required 0/1", name, out_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || res_a !== 16'h0 || res_b !== 16'h0 ||
            {z_flag, n_flag, c_flag} !== 3'b000) begin
            failures++;
            $display("FAIL reset: in_ready=%b out_valid=%b res_a=%h res_b=%h flags=%b required 1 0 0000 0000 000",
                     in_ready, out_valid, res_a, res_b, {z_flag, n_flag, c_flag});
        end
    endtask

    task automatic test_arith();
        run_op(4'h4, 3'b000, 16'hFFFF, 16'h0001, lat);
        checks++;
        if (lat !== 1 || res_a !== 16'h0000 || res_b !== 16'h0001 || {z_flag, n_flag, c_flag} !== 3'b101) begin
            failures++;
            $display("FAIL add: lat=%0d res_a=%h res_b=%h zNc=%b required 1 0000 0001 101",
                     lat, res_a, res_b, {z_flag, n_flag, c_flag});
        end
        take_result("add");
        run_op(4'h5, 3'b000, 16'h0003, 16'h0005, lat);
        checks++;
        if (lat !== 1 || res_a !== 16'hFFFE || {z_flag, n_flag, c_flag} !== 3'b011) begin
            failures++;
            $display("FAIL sub: lat=%0d res_a=%h zNc=%b required 1 fffe 011", lat, res_a, {z_flag, n_flag, c_flag});
        end
        take_result("sub");
        run_op(4'hC, 3'b000, 16'h0005, 16'h0005, lat);
        checks++;
        if (res_a !== 16'h0005 || res_b !== 16'h0005 || {z_flag, n_flag, c_flag} !== 3'b100) begin
            failures++;
            $display("FAIL cmp: res_a=%h res_b=%h zNc=%b required 0005 0005 100", res_a, res_b, {z_flag, n_flag, c_flag});
        end
        take_result("cmp");
    endtask

    task automatic test_logic();
        run_op(4'h5, 3'b000, 16'h0001, 16'h0002, lat);
        take_result("sub_setup");
        run_op(4'h6, 3'b000, 16'h00F0, 16'h8F00, lat);
        checks++;
        if (res_a !== 16'h8FF0 || res_b !== 16'h8F00 || {z_flag, n_flag, c_flag} !== 3'b010) begin
            failures++;
            $display("FAIL or: res_a=%h res_b=%h zNc=%b required 8ff0 8f00 010", res_a, res_b, {z_flag, n_flag, c_flag});
        end
        take_result("or");
        run_op(4'h7, 3'b000, 16'h0F0F, 16'h3355, lat);
        checks++;
        if (res_a !== 16'h0305 || {z_flag, n_flag, c_flag} !== 3'b000) begin
            failures++;
            $display("FAIL and: res_a=%h zNc=%b required 0305 000", res_a, {z_flag, n_flag, c_flag});
        end
        take_result("and");
        run_op(4'h8, 3'b000, 16'hAAAA, 16'hAAAA, lat);
        checks++;
        if (res_a !== 16'h0000 || {z_flag, n_flag, c_flag} !== 3'b100) begin
            failures++;
            $display("FAIL xor: res_a=%h zNc=%b required 0000 100", res_a, {z_flag, n_flag, c_flag});
        end
        take_result("xor");
    endtask

    task automatic test_shr();
        run_op(4'h9, 3'b000, 16'h8001, 16'h0004, lat);
        checks++;
        if (lat !== 5 || res_a !== 16'h0800 || res_b !== 16'h0004 || {z_flag, n_flag, c_flag} !== 3'b100) begin
            failures++;
            $display("FAIL shr4: lat=%0d res_a=%h res_b=%h zNc=%b required 5 0800 0004 100",
                     lat, res_a, res_b, {z_flag, n_flag, c_flag});
        end
        take_result("shr4");
        run_op(4'h9, 3'b000, 16'h8001, 16'h0001, lat);
        checks++;
        if (lat !== 2 || res_a !== 16'h4000 || {z_flag, n_flag, c_flag} !== 3'b101) begin
            failures++;
            $display("FAIL shr1: lat=%0d res_a=%h zNc=%b required 2 4000 101", lat, res_a, {z_flag, n_flag, c_flag});
        end
        take_result("shr1");
        run_op(4'h9, 3'b000, 16'h1234, 16'h0010, lat);
        checks++;
        if (lat !== 1 || res_a !== 16'h1234 || res_b !== 16'h0010 || {z_flag, n_flag, c_flag} !== 3'b101) begin
            failures++;
            $display("FAIL shr0: lat=%0d res_a=%h res_b=%h zNc=%b required 1 1234 0010 101",
                     lat, res_a, res_b, {z_flag, n_flag, c_flag});
        end
        take_result("shr0");
    endtask

    task automatic test_move();
        run_op(4'hA, 3'b000, 16'h1234, 16'h5678, lat);
        checks++;
        if (res_a !== 16'h1234 || res_b !== 16'h1234 || {z_flag, n_flag, c_flag} !== 3'b101) begin
            failures++;
            $display("FAIL mov: res_a=%h res_b=%h zNc=%b required 1234 1234 101", res_a, res_b, {z_flag, n_flag, c_flag});
        end
        take_result("mov");
        run_op(4'hB, 3'b000, 16'h1234, 16'h5678, lat);
        checks++;
        if (res_a !== 16'h5678 || res_b !== 16'h1234 || {z_flag, n_flag, c_flag} !== 3'b101) begin
            failures++;
            $display("FAIL exch: res_a=%h res_b=%h zNc=%b required 5678 1234 101", res_a, res_b, {z_flag, n_flag, c_flag});
        end
        take_result("exch");
        run_op(4'h0, 3'b111, 16'hBEEF, 16'hCAFE, lat);
        checks++;
        if (lat !== 1 || res_a !== 16'hBEEF || res_b !== 16'hCAFE || {z_flag, n_flag, c_flag} !== 3'b101) begin
            failures++;
            $display("FAIL pass0: lat=%0d res_a=%h res_b=%h zNc=%b required 1 beef cafe 101",
                     lat, res_a, res_b, {z_flag, n_flag, c_flag});
        end
        take_result("pass0");
    endtask

    task automatic test_set_clr();
        logic [15:0] ha, hb;
        logic [2:0]  hf;
        run_op(4'hE, 3'b111, 16'h0000, 16'h0000, lat);
        take_result("clr_all");
        run_op(4'hD, 3'b101, 16'h0011, 16'h0022, lat);
        checks++;
        if (res_a !== 16'h0011 || res_b !== 16'h0022 || {z_flag, n_flag, c_flag} !== 3'b101) begin
            failures++;
            $display("FAIL set: res_a=%h res_b=%h zNc=%b required 0011 0022 101", res_a, res_b, {z_flag, n_flag, c_flag});
        end
        take_result("set");
        run_op(4'hE, 3'b001, 16'h0033, 16'h0044, lat);
        checks++;
        if ({z_flag, n_flag, c_flag} !== 3'b100) begin
            failures++;
            $display("FAIL clr: zNc=%b required 100", {z_flag, n_flag, c_flag});
        end
        ha = 16'h0033; hb = 16'h0044; hf = 3'b100;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            opcode = 4'h4; a_in = 16'h0101; b_in = 16'h0202; in_valid = 1'b1;
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || res_a !== ha || res_b !== hb ||
                {z_flag, n_flag, c_flag} !== hf) begin
                failures++;
                $display("FAIL hold%0d: out_valid=%b in_ready=%b res_a=%h res_b=%h zNc=%b required 1 0 %h %h %b",
                         i, out_valid, in_ready, res_a, res_b, {z_flag, n_flag, c_flag}, ha, hb, hf);
            end
        end
        in_valid = 1'b0;
        take_result("clr");
    endtask

    task automatic test_op3();
`ifdef SEQ_ALU_MUL_EN
        run_op(4'h3, 3'b000, 16'h0100, 16'h0100, lat);
        checks++;
        if (lat !== 17 || res_a !== 16'h0000 || res_b !== 16'h0001 || {z_flag, n_flag, c_flag} !== 3'b001) begin
            failures++;
            $display("FAIL mul: lat=%0d res_a=%h res_b=%h zNc=%b required 17 0000 0001 001",
                     lat, res_a, res_b, {z_flag, n_flag, c_flag});
        end
        take_result("mul");
        run_op(4'h3, 3'b000, 16'hFFFF, 16'hFFFF, lat);
        checks++;
        if (res_a !== 16'h0001 || res_b !== 16'hFFFE || {z_flag, n_flag, c_flag} !== 3'b011) begin
            failures++;
            $display("FAIL mul_max: res_a=%h res_b=%h zNc=%b required 0001 fffe 011", res_a, res_b, {z_flag, n_flag, c_flag});
        end
        take_result("mul_max");
`else
        run_op(4'h3, 3'b000, 16'h1111, 16'h2222, lat);
        checks++;
        if (lat !== 1 || res_a !== 16'h1111 || res_b !== 16'h2222 || {z_flag, n_flag, c_flag} !== 3'b100) begin
            failures++;
            $display("FAIL op3_pass: lat=%0d res_a=%h res_b=%h zNc=%b required 1 1111 2222 100",
                     lat, res_a, res_b, {z_flag, n_flag, c_flag});
        end
        take_result("op3_pass");
`endif
    endtask

    task automatic test_reset_mid();
        int seen;
        @(negedge clk);
        opcode = 4'h9; a_in = 16'hFFFF; b_in = 16'h0008; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || {z_flag, n_flag, c_flag} !== 3'b000) begin
            failures++;
            $display("FAIL midrst: out_valid=%b in_ready=%b zNc=%b required 0 1 000",
                     out_valid, in_ready, {z_flag, n_flag, c_flag});
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL midrst_quiet: bad cycles=%0d required 0", seen);
        end
        run_op(4'h4, 3'b000, 16'h0002, 16'h0003, lat);
        checks++;
        if (lat !== 1 || res_a !== 16'h0005 || {z_flag, n_flag, c_flag} !== 3'b000) begin
            failures++;
            $display("FAIL post_rst_add: lat=%0d res_a=%h zNc=%b required 1 0005 000", lat, res_a, {z_flag, n_flag, c_flag});
        end
        take_result("post_rst_add");
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        opcode = 4'h0; flag_mask = 3'b000; a_in = 16'h0; b_in = 16'h0;
        @(posedge clk); @(posedge clk); #1;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        test_arith();
        test_logic();
        test_shr();
        test_move();
        test_set_clr();
        test_op3();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seq_alu.md
# seq_alu

Multi-cycle, parametrised ALU for the S-Machine CPU datapath; the successor to the single-cycle combinational ALU. It accepts one operation at a time over a valid/ready handshake and keeps the Z/N/C status flags in an internal register rather than taking them as inputs. Results are held under output backpressure. Over the single-cycle ALU it adds multi-bit iterative SHR, a true carry/borrow on ADD/SUB, and an optional iterative multiply. It sits between the register file read ports and the writeback stage.

## Interface
- `WIDTH`, default 16: data width of operands and results (≥4).
- `SHAMT_W`, default `$clog2(WIDTH)`: width of the SHR shift-count field.
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  operation offered.
- `in_ready`  out  1  block can accept an operation.
- `opcode`  in  4  instruction bits [15:12].
- `flag_mask`  in  3  instruction bits [10:8], as {Z,N,C}; used by SET and CLR.
- `a_in`, `b_in`  in  WIDTH  operands A and B.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer takes the result.
- `res_a`, `res_b`  out  WIDTH  results for the A and B destinations.
- `z_flag`, `n_flag`, `c_flag`  out  1  registered status flags.

## Operation
- Opcodes: 4 ADD, 5 SUB, 6 OR, 7 AND, 8 XOR, 9 SHR, A MOV, B EXCH, C CMP, D SET, E CLR, 3 MUL (macro only).
- All other opcodes pass through: res_a=a_in, res_b=b_in, flags unchanged.
- ADD: C = carry out of the (WIDTH+1)-bit sum.
- SUB and CMP: C = borrow, i.e. (a_in < b_in unsigned).
- OR/AND/XOR: C cleared.
- ADD/SUB/logic ops and CMP set Z = (result==0) and N = result MSB.
- CMP discards its result: res_a=a_in, res_b=b_in.
- SHR: logical right shift of a_in by b_in[SHAMT_W-1:0], one bit per cycle.
  - C = last bit shifted out; Z and N unchanged.
  - Count 0: res_a=a_in, C unchanged.
- MOV: res_b=a_in, res_a=a_in. EXCH: res_a=b_in, res_b=a_in. Flags unchanged for both.
- SET/CLR: force to 1 / 0 each flag whose `flag_mask` bit is 1; operands pass through.
- For every opcode, res_a/res_b not named above equal a_in/b_in.
- FSM states:
  - IDLE: in_ready=1. On accept, go to SHIFT (SHR, count>0), MUL (MUL), or DONE (all others).
  - SHIFT: decrements the counter; enters DONE when the counter reaches 0.
  - MUL: runs WIDTH cycles, then enters DONE.
  - DONE: out_valid=1 and holds res_a, res_b and the flags stable. Returns to IDLE on out_ready.
- Flags register updates once per operation, on the edge entering DONE.

## Timing
- Reset values: in_ready=1, out_valid=0, res_a=res_b=0, flags=0, state IDLE.
- Reset mid-operation aborts immediately with no result emitted.
- Accept edge t: out_valid rises at t+1 for single-cycle ops, t+1+k for SHR by k, and t+1+WIDTH for MUL.
- in_ready=0 from t+1 until the cycle after the DONE→IDLE handshake; there is no overlap of operations.
- out_valid&&out_ready at edge u: out_valid=0 and in_ready=1 at u+1.
- in_valid while in_ready=0 is ignored; the source must hold its operation until accepted.

## Configuration
- `SEQ_ALU_MUL_EN` defined:
  - Opcode 3 is an unsigned shift-add multiply, one partial product per cycle.
  - res_a = low WIDTH bits, res_b = high WIDTH bits.
  - Z = (full 2·WIDTH-bit product==0), N = res_b MSB, C = (res_b != 0).
- Undefined: opcode 3 is a pass-through, the MUL state and its datapath are absent, and latency is 1.

## Structure
- Package `seq_alu_pkg`: opcode localparams, FSM state enum, flag index constants {Z=2,N=1,C=0}.
- Sub-module `seq_alu_iter`: shift/multiply datapath holding the counter, shift register and accumulator. Interface: start, done, operands, results, last-out bit. The MUL part is guarded by the macro.
- Top level: FSM, single-cycle combinational ops, flag register, handshake.

## Test plan
- ADD 0xFFFF+0x0001, WIDTH=16 → res_a=0x0000, Z=1, N=0, C=1; out_valid at t+1.
- SUB 3−5 → res_a=0xFFFE, N=1, C=1. CMP 5,5 → Z=1, C=0, res_a=5.
- SHR 0x8001 by 4 → res_a=0x0800, C=0, out_valid at t+5. SHR by 1 → 0x4000, C=1. SHR by 0 → C unchanged.
- SET mask 3'b101, then CLR mask 3'b001, from flags 000 → flags Z=1, N=0, C=0. Hold out_ready=0 for 3 cycles → outputs stable and in_ready=0.
- With `SEQ_ALU_MUL_EN`: 0x0100×0x0100 → res_a=0x0000, res_b=0x0001, C=1, out_valid at t+17. Without it: opcode 3 passes through at t+1.
- Drop rst_n at t+2 during SHR by 8 → out_valid=0, flags=000, in_ready=1 after release, and the next ADD completes normally.
